// File: rtl/pipeline_step_scheduler.sv
// Debug-path sequencer for the MIPS pipeline global step enable and pipeline reset.
// Optional breakpoint compare enabled by defining PIPELINE_STEP_SCHEDULER_BKPT_EN.
module pipeline_step_scheduler #(
  parameter int NBITS      = 32,
  parameter int STEP_CNT_W = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  input  logic [1:0]            i_cmd,
  input  logic [STEP_CNT_W-1:0] i_cmd_count,
  output logic                  o_cmd_ready,
  input  logic                  i_abort,
  input  logic                  i_mips_halt,
  input  logic [NBITS-1:0]      i_pc,
`ifdef PIPELINE_STEP_SCHEDULER_BKPT_EN
  input  logic                  i_bkpt_en,
  input  logic [NBITS-1:0]      i_bkpt_addr,
`endif
  output logic                  o_mips_step,
  output logic                  o_mips_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_done_cause,
  output logic [STEP_CNT_W-1:0] o_steps_taken,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RST_HOLD = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [1:0] CMD_RESET = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_BURST = 2'b10;
  localparam logic [1:0] CMD_RUN   = 2'b11;

  localparam logic [1:0] CAUSE_COUNT = 2'b00;
  localparam logic [1:0] CAUSE_HALT  = 2'b01;
  localparam logic [1:0] CAUSE_ABORT = 2'b10;
  localparam logic [1:0] CAUSE_BKPT  = 2'b11;

  localparam logic [7:0]            HOLD_INIT = 8'(RST_CYCLES);
  localparam logic [STEP_CNT_W-1:0] CNT_ONE   = STEP_CNT_W'(1);

  state_t                state_q, state_d;
  logic [7:0]            hold_q, hold_d;
  logic [STEP_CNT_W-1:0] limit_q, limit_d;
  logic                  unlim_q, unlim_d;
  logic [STEP_CNT_W-1:0] steps_q, steps_d;
  logic                  step_q, step_d;
  logic                  mrst_q, mrst_d;
  logic                  done_q, done_d;
  logic [1:0]            cause_q, cause_d;
  logic                  por_q, por_d;
  logic                  first_q, first_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  bkpt_hit_s;
  logic                  count_hit_s;

`ifdef PIPELINE_STEP_SCHEDULER_BKPT_EN
  // The first step after accept never matches, so a run can resume from the breakpoint PC.
  assign bkpt_hit_s = i_bkpt_en && (i_pc == i_bkpt_addr) && !first_q;
`else
  logic unused_pc_s;
  assign unused_pc_s = ^{i_pc, first_q};
  assign bkpt_hit_s  = 1'b0;
`endif

  assign count_hit_s = !unlim_q &&
                       (({1'b0, steps_q} + {{STEP_CNT_W{1'b0}}, 1'b1}) == {1'b0, limit_q});

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    limit_d = limit_q;
    unlim_d = unlim_q;
    steps_d = steps_q;
    step_d  = step_q;
    mrst_d  = mrst_q;
    done_d  = 1'b0;
    cause_d = cause_q;
    por_d   = por_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          steps_d = '0;
          unlim_d = (i_cmd == CMD_RUN);
          limit_d = (i_cmd == CMD_BURST) ? i_cmd_count : CNT_ONE;
          if (i_cmd == CMD_RESET) begin
            state_d = ST_RST_HOLD;
            mrst_d  = 1'b1;
            hold_d  = HOLD_INIT;
            por_d   = 1'b0;
          end else if (i_mips_halt) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            cause_d = CAUSE_HALT;
          end else if ((i_cmd == CMD_BURST) && (i_cmd_count == '0)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            cause_d = CAUSE_COUNT;
          end else begin
            state_d = ST_RUN;
            step_d  = 1'b1;
            first_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RST_HOLD: begin
        if (hold_q <= 8'd1) begin
          mrst_d  = 1'b0;
          por_d   = 1'b0;
          if (por_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            cause_d = CAUSE_COUNT;
          end
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      ST_RUN: begin
        steps_d = (&steps_q) ? steps_q : (steps_q + CNT_ONE);
        first_d = 1'b0;
        if (i_abort || i_mips_halt || bkpt_hit_s || count_hit_s) begin
          state_d = ST_DONE;
          step_d  = 1'b0;
          done_d  = 1'b1;
          if (i_abort) begin
            cause_d = CAUSE_ABORT;
          end else if (i_mips_halt) begin
            cause_d = CAUSE_HALT;
          end else if (bkpt_hit_s) begin
            cause_d = CAUSE_BKPT;
          end else begin
            cause_d = CAUSE_COUNT;
          end
        end else begin
          step_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 1'b0;
        mrst_d  = 1'b0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers; reset starts a power-on pipeline reset hold.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_RST_HOLD;
      hold_q  <= HOLD_INIT;
      limit_q <= '0;
      unlim_q <= 1'b0;
      steps_q <= '0;
      step_q  <= 1'b0;
      mrst_q  <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= 2'b00;
      por_q   <= 1'b1;
      first_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      limit_q <= limit_d;
      unlim_q <= unlim_d;
      steps_q <= steps_d;
      step_q  <= step_d;
      mrst_q  <= mrst_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      por_q   <= por_d;
      first_q <= first_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign o_cmd_ready   = ready_q;
  assign o_busy        = busy_q;
  assign o_mips_step   = step_q;
  assign o_mips_rst    = mrst_q;
  assign o_done        = done_q;
  assign o_done_cause  = cause_q;
  assign o_steps_taken = steps_q;
  assign o_state       = state_q;

endmodule

// File: doc/pipeline_step_scheduler.md
Name: pipeline_step_scheduler

Overview:
Sequences the MIPS pipeline's global step enable and pipeline reset for the debug path. Accepts one command at a time from the debug controller: reset pipeline, single step, N-step burst, or free run. Asserts the pipeline step strobe cycle by cycle and stops on one of four events: count exhausted, pipeline halt, abort, or breakpoint. Reports completion, the cause and the number of steps taken. Sits between the debug unit and the step/reset inputs shared by the IF, ID and MA stages and all pipeline registers.

Parameters:
NBITS, 32, width of the PC input
STEP_CNT_W, 16, width of the step count and the step counter
RST_CYCLES, 4, number of cycles o_mips_rst is held per reset (1..255)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-low reset
i_cmd_valid  in  1  command request
i_cmd  in  2  00 reset pipeline, 01 single step, 10 burst, 11 run
i_cmd_count  in  STEP_CNT_W  burst length; sampled on accept
o_cmd_ready  out  1  high only in IDLE
i_abort  in  1  stop a RUN or burst in progress
i_mips_halt  in  1  halt flag from the MA/WB stage
i_pc  in  NBITS  current fetch PC
o_mips_step  out  1  pipeline step enable (registered)
o_mips_rst  out  1  pipeline reset, active-high (registered)
o_busy  out  1  state is not IDLE
o_done  out  1  one-cycle completion pulse
o_done_cause  out  2  00 count/reset, 01 halt, 10 abort, 11 breakpoint; held until the next done
o_steps_taken  out  STEP_CNT_W  steps issued by the last command; saturating
o_state  out  2  IDLE=0, RST_HOLD=1, RUN=2, DONE=3

Behaviour:
- Reset (i_rst=0, asynchronous) drives these values:
  - state = RST_HOLD
  - o_mips_rst = 1, o_mips_step = 0
  - o_done = 0, o_done_cause = 00, o_steps_taken = 0
  - o_busy = 1, o_cmd_ready = 0
  - the internal hold counter loads RST_CYCLES
  - the post-reset hold goes straight to IDLE with no o_done pulse.
- Handshake: a command is accepted on a rising edge with i_cmd_valid=1 and o_cmd_ready=1. o_cmd_ready is 1 only in IDLE. A command is never queued.
- On accept:
  - o_steps_taken clears to 0.
  - The count limit latches: single step uses 1, burst uses i_cmd_count, run has no limit.
- Reset command: go to RST_HOLD. o_mips_rst=1 for exactly RST_CYCLES cycles, then DONE with cause 00. i_abort is ignored in RST_HOLD.
- Step, burst or run with i_mips_halt=1 at accept: DONE next cycle, cause 01, zero steps, o_mips_step never asserted.
- Burst with count 0: DONE next cycle, cause 00, zero steps.
- Otherwise: go to RUN; o_mips_step=1 from the cycle after accept.
- Each edge in RUN with o_mips_step=1 increments o_steps_taken (saturating at all-ones).
- At each edge in RUN, termination is evaluated with priority abort > halt > breakpoint > count:
  - abort: i_abort=1
  - halt: i_mips_halt=1; the step in the current cycle still counts
  - count: steps_taken+1 == limit
- On termination: o_mips_step=0 on the next cycle, state = DONE, o_done_cause updated.
- Latency: a single step produces exactly one o_mips_step cycle, and o_done follows it on the next cycle.
- DONE lasts one cycle (o_done=1), then IDLE.
- i_abort in IDLE or DONE has no effect.
- o_mips_step and o_mips_rst are never high together.
- o_busy = (state != IDLE).

Optional Feature:
PIPELINE_STEP_SCHEDULER_BKPT_EN
- With the macro defined, ports i_bkpt_en (1) and i_bkpt_addr (NBITS) exist.
- In RUN, when i_bkpt_en=1 and i_pc==i_bkpt_addr at an edge, the run terminates with cause 11. Abort and halt take priority over the breakpoint.
- The breakpoint check is skipped on the first step after accept, so execution can resume from the breakpoint PC.
- Without the macro, these ports are absent and cause 11 never occurs.

Test Plan:
- Release i_rst -> o_mips_rst=1 for 4 cycles, then IDLE, o_cmd_ready=1, no o_done.
- Single step, halt low -> exactly 1 o_mips_step cycle; o_done next cycle; cause 00; o_steps_taken=1.
- Burst count=5, halt low -> 5 consecutive step cycles; o_steps_taken=5; cause 00. Then burst count=0 -> no step, done with cause 00.
- Run; i_mips_halt rises during the 7th step cycle -> step drops after 7; cause 01; o_steps_taken=7. Step with halt already high -> 0 steps, cause 01.
- Run; i_abort and i_mips_halt both high on the same edge -> cause 10 (abort wins). Reset command while i_abort=1 -> full 4-cycle hold, then cause 00.
- With the BKPT macro: i_bkpt_addr=0x10 and PC reaches 0x10 after 4 steps -> cause 11, o_steps_taken=4. Re-issue run -> PC advances past 0x10.
